// File: rtl/fb_rect_filler.sv
// fb_rect_filler: command-driven raster sequencer for the 120x60, 3-bit frame
// buffer write port. Accepts a fill-rectangle or clear-screen command, then
// issues one registered pixel write per clock in raster order (column fastest)
// and pulses done for one cycle when the command completes.
//
// Build option: define FB_CLIP_EN to clip rectangles against WIDTH x HEIGHT.
// Without it, exactly w*h writes are issued and the caller keeps rectangles
// in bounds (the address is simply truncated to AW bits).
module fb_rect_filler #(
    parameter int WIDTH  = 120,
    parameter int HEIGHT = 60,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [6:0]    cmd_x,
    input  logic [5:0]    cmd_y,
    input  logic [6:0]    cmd_w,
    input  logic [5:0]    cmd_h,
    input  logic [2:0]    cmd_color,
    output logic          busy,
    output logic          done,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [2:0]    di
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Screen dimensions as 8-bit constants so all coordinate maths stays 8-bit.
    localparam logic [7:0] WIDTH8  = 8'(WIDTH);
    localparam logic [7:0] HEIGHT8 = 8'(HEIGHT);

    state_t state_reg, state_next;

    // Raster walk state: current column/row, column restart value and the
    // exclusive end coordinates of the (possibly clipped) rectangle.
    logic [7:0]    col_reg;
    logic [7:0]    col_start_reg;
    logic [7:0]    col_end_reg;
    logic [7:0]    row_reg;
    logic [7:0]    row_end_reg;
    logic [AW-1:0] row_base_reg;

    // Registered frame buffer write port.
    logic          wr_reg;
    logic [AW-1:0] addr_reg;
    logic [2:0]    di_reg;

    // Command decode.
    logic [7:0]    x_sel, y_sel, w_sel, h_sel;
    logic [7:0]    x_end, y_end;
    logic          empty_cmd;
    logic [AW-1:0] y_terms [0:7];
    logic [AW-1:0] y_base;

    logic accept;
    logic last_col;
    logic last_row;
    logic last_pix;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == FILL);
    assign done      = (state_reg == FIN);
    assign wr        = wr_reg;
    assign addr      = addr_reg;
    assign di        = di_reg;

    assign accept   = (state_reg == IDLE) && cmd_valid;
    assign last_col = ((col_reg + 8'd1) == col_end_reg);
    assign last_row = ((row_reg + 8'd1) == row_end_reg);
    assign last_pix = last_col && last_row;

    // Select the effective rectangle; a clear ignores the geometry fields.
    always_comb begin
        x_sel = {1'b0, cmd_x};
        y_sel = {2'b00, cmd_y};
        w_sel = {1'b0, cmd_w};
        h_sel = {2'b00, cmd_h};
        if (cmd_op) begin
            x_sel = 8'd0;
            y_sel = 8'd0;
            w_sel = WIDTH8;
            h_sel = HEIGHT8;
        end
    end

    // End coordinates and the "nothing to write" decision. 8-bit sums cannot
    // overflow for 7-bit/6-bit operands.
`ifdef FB_CLIP_EN
    always_comb begin
        x_end     = x_sel + w_sel;
        y_end     = y_sel + h_sel;
        if (x_end > WIDTH8) begin
            x_end = WIDTH8;
        end
        if (y_end > HEIGHT8) begin
            y_end = HEIGHT8;
        end
        empty_cmd = (w_sel == 8'd0) || (h_sel == 8'd0) ||
                    (x_sel >= WIDTH8) || (y_sel >= HEIGHT8);
    end
`else
    always_comb begin
        x_end     = x_sel + w_sel;
        y_end     = y_sel + h_sel;
        empty_cmd = (w_sel == 8'd0) || (h_sel == 8'd0);
    end
`endif

    // Starting row base y*WIDTH built as a sum of shifted copies of y, one per
    // set bit of the constant WIDTH; later rows are reached by adding WIDTH.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row_base
            assign y_terms[gi] = WIDTH8[gi] ? (AW'(y_sel) << gi) : '0;
        end
    endgenerate

    // Sum of the shifted partial terms.
    always_comb begin
        y_base = '0;
        for (int i = 0; i < 8; i++) begin
            y_base = y_base + y_terms[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. An empty command still passes through FILL (with no
    // writes) so done lands two cycles after acceptance.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (!wr_reg || last_pix) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster walk and registered write port. The first write is loaded at the
    // accepting edge so wr is high in the first FILL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg       <= '0;
            col_start_reg <= '0;
            col_end_reg   <= '0;
            row_reg       <= '0;
            row_end_reg   <= '0;
            row_base_reg  <= '0;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            di_reg        <= '0;
        end else if (accept) begin
            col_reg       <= x_sel;
            col_start_reg <= x_sel;
            col_end_reg   <= x_end;
            row_reg       <= y_sel;
            row_end_reg   <= y_end;
            row_base_reg  <= y_base;
            wr_reg        <= !empty_cmd;
            if (!empty_cmd) begin
                addr_reg <= y_base + AW'(x_sel);
                di_reg   <= cmd_color;
            end
        end else if ((state_reg == FILL) && wr_reg) begin
            if (last_pix) begin
                wr_reg <= 1'b0;
            end else if (last_col) begin
                col_reg      <= col_start_reg;
                row_reg      <= row_reg + 8'd1;
                row_base_reg <= row_base_reg + AW'(WIDTH);
                addr_reg     <= row_base_reg + AW'(WIDTH) + AW'(col_start_reg);
            end else begin
                col_reg  <= col_reg + 8'd1;
                addr_reg <= addr_reg + AW'(1);
            end
        end else begin
            wr_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_rect_filler.sv
// Testbench for fb_rect_filler: table of commands with expected write count
// and first address, a scoreboard queue of expected (addr, di) writes filled
// from a reference painter, a frame buffer image compare, plus hand-written
// idle and mid-operation reset sequences.
module tb_fb_rect_filler;

    localparam int WIDTH  = 120;
    localparam int HEIGHT = 60;
    localparam int AW     = 16;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [6:0]    cmd_x;
    logic [5:0]    cmd_y;
    logic [6:0]    cmd_w;
    logic [5:0]    cmd_h;
    logic [2:0]    cmd_color;
    logic          busy;
    logic          done;
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    di;

    fb_rect_filler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .wr        (wr),
        .addr      (addr),
        .di        (di)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        int         x;
        int         y;
        int         w;
        int         h;
        logic [2:0] color;
        int         exp_n;
        int         exp_first;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    di;
    } wr_t;

    wr_t        sb_q[$];
    vec_t       vq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_wr = 0;
    int         first_wr_cyc = 0;
    int         last_wr_cyc = 0;
    logic [AW-1:0] first_addr = '0;
    logic [2:0] fb_img  [0:NPIX-1];
    logic [2:0] ref_img [0:NPIX-1];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write is compared against the scoreboard and stored in
    // the frame buffer model.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_t e;
            if (n_wr == 0) begin
                first_wr_cyc = cyc;
                first_addr   = addr;
            end
            last_wr_cyc = cyc;
            n_wr++;
            if (int'(addr) < NPIX) fb_img[addr] = di;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d di %0d, none expected", addr, di);
            end else begin
                e = sb_q.pop_front();
                if (e.addr !== addr || e.di !== di || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL write: got addr %0d di %0d busy %0b, expected addr %0d di %0d busy 1",
                             addr, di, busy, e.addr, e.di);
                end
            end
        end
    end

    // Reference painter: raster walk with an explicit multiply per pixel.
    task automatic model_cmd(input logic op, input int x, input int y, input int w,
                             input int h, input logic [2:0] color);
        wr_t e;
        int a;
        if (op) begin
            x = 0; y = 0; w = WIDTH; h = HEIGHT;
        end
        for (int r = y; r < y + h; r++) begin
            for (int c = x; c < x + w; c++) begin
`ifdef FB_CLIP_EN
                if (c >= WIDTH || r >= HEIGHT) continue;
`endif
                a = (r * WIDTH + c) % 65536;
                e.addr = AW'(a);
                e.di   = color;
                sb_q.push_back(e);
                if (a < NPIX) ref_img[a] = color;
            end
        end
    endtask

    task automatic drive_cmd(input logic op, input int x, input int y, input int w,
                             input int h, input logic [2:0] color);
        cmd_op    = op;
        cmd_x     = 7'(x);
        cmd_y     = 6'(y);
        cmd_w     = 7'(w);
        cmd_h     = 6'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
    endtask

    task automatic compare_image(input string name);
        int diffs = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (fb_img[i] !== ref_img[i]) diffs++;
        end
        chk(name, diffs, 0);
    endtask

    // Issue one command at a negedge while cmd_ready is high and check the
    // write run, done timing and the return of cmd_ready.
    task automatic run_cmd(input vec_t v, input int idx);
        int  a;
        int  t;
        int  dc = 0;
        bit  seen = 0;
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
        model_cmd(v.op, v.x, v.y, v.w, v.h, v.color);
        n_wr = 0;
        drive_cmd(v.op, v.x, v.y, v.w, v.h, v.color);
        a = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x = 7'($urandom); cmd_y = 6'($urandom);
        cmd_w = 7'($urandom); cmd_h = 6'($urandom);
        t = 0;
        while (!seen && t < v.exp_n + 20) begin
            if (done === 1'b1) begin
                seen = 1;
                dc   = cyc;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), 32'(seen), 1);
        chk($sformatf("v%0d_wr_count", idx), n_wr, v.exp_n);
        chk($sformatf("v%0d_done_latency", idx), dc - a, (v.exp_n > 0) ? v.exp_n + 1 : 2);
        if (v.exp_n > 0) begin
            chk($sformatf("v%0d_first_wr_cycle", idx), first_wr_cyc - a, 1);
            chk($sformatf("v%0d_run_length", idx), last_wr_cyc - first_wr_cyc + 1, v.exp_n);
            chk($sformatf("v%0d_first_addr", idx), 32'(first_addr), v.exp_first);
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse_width", idx), done, 0);
        chk($sformatf("v%0d_ready_after_done", idx), cmd_ready, 1);
        chk($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
        sb_q.delete();
        compare_image($sformatf("v%0d_image", idx));
        if (v.op && v.color == 3'd0) begin
            int nz = 0;
            for (int i = 0; i < NPIX; i++) begin
                if (fb_img[i] !== 3'd0) nz++;
            end
            chk($sformatf("v%0d_cleared_zero", idx), nz, 0);
        end
    endtask

    initial begin
        int a;
        for (int i = 0; i < NPIX; i++) begin
            fb_img[i]  = 3'd0;
            ref_img[i] = 3'd0;
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

        // Command table: op, x, y, w, h, color, expected writes, first address.
        vq.push_back('{1'b1, 0,   0,  0,   0,  3'd3, NPIX, 0});
        vq.push_back('{1'b0, 10,  2,  3,   2,  3'd5, 6,    250});
        vq.push_back('{1'b0, 0,   0,  1,   1,  3'd2, 1,    0});
        vq.push_back('{1'b0, 119, 0,  1,   60, 3'd6, 60,   119});
        vq.push_back('{1'b0, 5,   7,  0,   4,  3'd3, 0,    0});
        vq.push_back('{1'b0, 0,   59, 120, 1,  3'd1, 120,  7080});
`ifdef FB_CLIP_EN
        vq.push_back('{1'b0, 118, 59, 4,   3,  3'd7, 2,    7198});
        vq.push_back('{1'b0, 120, 5,  3,   3,  3'd1, 0,    0});
`else
        vq.push_back('{1'b0, 118, 59, 4,   3,  3'd7, 12,   7198});
`endif
        vq.push_back('{1'b0, 50,  20, 7,   0,  3'd4, 0,    0});
        vq.push_back('{1'b1, 50,  30, 3,   3,  3'd0, NPIX, 0});

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: outputs at their reset values for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), {28'd0, cmd_ready, wr, busy, done}, 32'b1000);
        end
        chk("idle_addr_di", {13'd0, di, addr}, 0);

        for (int i = 0; i < vq.size(); i++) begin
            run_cmd(vq[i], i);
        end

        // Reset during the third write of a 4x4 fill: only three pixels land.
        @(negedge clk);
        chk("rst_seq_ready", cmd_ready, 1);
        model_cmd(1'b0, 20, 10, 3, 1, 3'd2);
        n_wr = 0;
        drive_cmd(1'b0, 20, 10, 4, 4, 3'd2);
        a = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc < a + 3) @(negedge clk);
        chk("rst_seq_third_wr", wr, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_seq_wr_low", wr, 0);
        chk("rst_seq_idle", {busy, cmd_ready}, 2'b01);
        chk("rst_seq_writes", n_wr, 3);
        begin
            int dones = 0;
            for (int i = 0; i < 6; i++) begin
                if (done === 1'b1) dones++;
                @(negedge clk);
            end
            chk("rst_seq_no_done", dones, 0);
        end
        chk("rst_seq_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        compare_image("rst_seq_image");

        // Fresh command after the abort completes normally.
        run_cmd('{1'b0, 40, 30, 4, 4, 3'd6, 16, 3640}, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
